load_store_unit: RTL

Byte/halfword/word load-store engine between the rv32i execute stage and the word-wide `ram` block. It takes one RV32I memory request at a time and checks alignment. It performs read-modify-write for sub-word stores, because `ram` has only a full-word write strobe. It returns sign- or zero-extended load data with a single-cycle valid pulse.

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response channel between the execute stage and the load/store unit.
// master = execute stage, slave = load_store_unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store engine in front of a word-wide RAM.
// Sub-word stores are done as read-modify-write because the RAM has a single word strobe.
module load_store_unit (
    input  logic                     i_clk,
    input  logic                     i_rst,
    load_store_unit_if.slave         io_lsu,
    output logic [31:0]              o_mem_addr,
    output logic                     o_mem_write,
    output logic [31:0]              o_mem_wdata,
    input  logic [31:0]              i_mem_rdata
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_req_err;
    logic [31:0] w_shift;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    // Alignment and funct3 legality of the request being offered in IDLE.
    always_comb begin
        w_req_err = 1'b0;
        if (io_lsu.req_we) begin
            case (io_lsu.req_funct3)
                3'b000:  w_req_err = 1'b0;
                3'b001:  w_req_err = io_lsu.req_addr[0];
                3'b010:  w_req_err = |io_lsu.req_addr[1:0];
                default: w_req_err = 1'b1;
            endcase
        end else begin
            case (io_lsu.req_funct3)
                3'b000, 3'b100: w_req_err = 1'b0;
                3'b001, 3'b101: w_req_err = io_lsu.req_addr[0];
                3'b010:         w_req_err = |io_lsu.req_addr[1:0];
                default:        w_req_err = 1'b1;
            endcase
        end
    end

    // Halfword accesses are aligned, so a byte-lane shift also selects the halfword.
    assign w_shift = i_mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_data = i_mem_rdata;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load_data = {24'd0, w_shift[7:0]};
            3'b101:  w_load_data = {16'd0, w_shift[15:0]};
            default: w_load_data = i_mem_rdata;
        endcase
    end

    always_comb begin
        w_merge = r_wdata;
        case (r_funct3)
            3'b000: begin
                w_merge = r_word;
                w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            3'b001: begin
                w_merge = r_word;
                w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next             = r_state;
        io_lsu.req_ready   = 1'b0;
        io_lsu.resp_valid  = 1'b0;
        o_mem_write        = 1'b0;
        o_mem_wdata        = 32'd0;
        case (r_state)
            S_IDLE: begin
                io_lsu.req_ready = ~i_rst;
                if (io_lsu.req_valid) begin
                    if (w_req_err) begin
                        w_next = S_RESP;
                    end else if (io_lsu.req_we && (io_lsu.req_funct3 == 3'b010)) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                w_next = r_we ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                o_mem_write = ~i_rst;
                o_mem_wdata = w_merge;
                w_next      = S_RESP;
            end
            S_RESP: begin
                io_lsu.resp_valid = ~i_rst;
                w_next            = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_word   <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && io_lsu.req_valid) begin
                r_we     <= io_lsu.req_we;
                r_funct3 <= io_lsu.req_funct3;
                r_addr   <= io_lsu.req_addr;
                r_wdata  <= io_lsu.req_wdata;
            end
            if (r_state == S_READ) begin
                r_word <= i_mem_rdata;
            end
            // Response registers change only on entry to RESP and hold until the next one.
            if (w_next == S_RESP) begin
                r_err   <= (r_state == S_IDLE);
                r_rdata <= (r_state == S_READ) ? w_load_data : 32'd0;
            end
        end
    end

    assign o_mem_addr        = {2'b00, r_addr[31:2]};
    assign io_lsu.resp_rdata = r_rdata;
    assign io_lsu.resp_err   = r_err;
endmodule
